// File: rtl/camera_stream_gen_if.sv
// camera_stream_gen_if: parallel camera bus (FVAL/LVAL/12-bit pixel) shared by
// the synthetic source and the capture receiver.
interface camera_stream_gen_if;
   logic [11:0] cam_d;
   logic        cam_fval;
   logic        cam_lval;
   modport master (output cam_d, cam_fval, cam_lval);
   modport slave  (input  cam_d, cam_fval, cam_lval);
endinterface

// File: rtl/camera_stream_gen.sv
// camera_stream_gen: synthetic FVAL/LVAL/12-bit pixel source with programmable geometry,
// test patterns and frame counter. Optional per-frame CRC-16 under CAMGEN_FRAME_CRC_EN.
module camera_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 16,
   parameter int FV_LEAD  = 8,
   parameter int FV_TRAIL = 8,
   parameter int V_GAP    = 32
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                enable,
   input  logic [1:0]          pattern_sel,
   camera_stream_gen_if.master cam,
   output logic [15:0]         frame_count,
   output logic                busy
`ifdef CAMGEN_FRAME_CRC_EN
   ,
   output logic [15:0]         frame_crc,
   output logic                crc_valid
`endif
);
   localparam int M1   = H_ACTIVE > H_BLANK ? H_ACTIVE : H_BLANK;
   localparam int M2   = FV_LEAD > FV_TRAIL ? FV_LEAD : FV_TRAIL;
   localparam int M3   = M1 > M2 ? M1 : M2;
   localparam int MAXC = M3 > V_GAP ? M3 : V_GAP;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int YW   = $clog2(V_ACTIVE + 1);
   localparam logic [CW-1:0] LEAD_LAST = CW'(FV_LEAD - 1);
   localparam logic [CW-1:0] H_LAST    = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] TR_LAST   = CW'(FV_TRAIL - 1);
   localparam logic [CW-1:0] VG_LAST   = CW'(V_GAP - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TRAIL, VGAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    pat_q, pat_d;
   logic [15:0]   frame_count_q, frame_count_d;
   logic [11:0]   cam_d_q, cam_d_d, x12, y12, pix;
   logic          fval_q, fval_d, lval_q, lval_d, busy_q, busy_d;
   logic          start, inc;

   // cnt_q is the position inside the current state; in LINE it is the pixel x
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      y_d     = y_q;
      pat_d   = pat_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            start = enable;
         end
         LEAD: if (cnt_q == LEAD_LAST) begin
            state_d = LINE;
            cnt_d   = '0;
         end
         LINE: if (cnt_q == H_LAST) begin
            state_d = (y_q == Y_LAST) ? TRAIL : HBLANK;
            cnt_d   = '0;
         end
         HBLANK: if (cnt_q == HB_LAST) begin
            state_d = LINE;
            cnt_d   = '0;
            y_d     = y_q + 1'b1;
         end
         TRAIL: if (cnt_q == TR_LAST) begin
            state_d = VGAP;
            cnt_d   = '0;
         end
         VGAP: if (cnt_q == VG_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            start   = enable;
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = LEAD;
         y_d     = '0;
         pat_d   = pattern_sel;
      end
      // outputs lag the state by one register, so the count bump lines up with FVAL falling
      inc           = (state_q == VGAP) && (cnt_q == '0);
      frame_count_d = inc ? frame_count_q + 16'd1 : frame_count_q;
      x12           = 12'(cnt_q);
      y12           = 12'(y_q);
      pix           = pat_q == 2'd0 ? x12 :
                      pat_q == 2'd1 ? y12 :
                      pat_q == 2'd2 ? {12{x12[3] ^ y12[3]}} : frame_count_q[11:0];
      fval_d        = state_q inside {LEAD, LINE, HBLANK, TRAIL};
      lval_d        = state_q == LINE;
      busy_d        = state_q != IDLE;
      cam_d_d       = lval_d ? pix : 12'h000;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         y_q           <= '0;
         pat_q         <= '0;
         frame_count_q <= '0;
         cam_d_q       <= '0;
         fval_q        <= 1'b0;
         lval_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         y_q           <= y_d;
         pat_q         <= pat_d;
         frame_count_q <= frame_count_d;
         cam_d_q       <= cam_d_d;
         fval_q        <= fval_d;
         lval_q        <= lval_d;
         busy_q        <= busy_d;
      end
   end

   assign cam.cam_d    = cam_d_q;
   assign cam.cam_fval = fval_q;
   assign cam.cam_lval = lval_q;
   assign frame_count  = frame_count_q;
   assign busy         = busy_q;

`ifdef CAMGEN_FRAME_CRC_EN
   logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;
   logic        crc_valid_q;

   function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   // CRC consumes the registered bus, so the last pixel is folded in during TRAIL
   always_comb begin
      crc_d       = (state_d == LEAD && state_q != LEAD) ? 16'hFFFF :
                    lval_q ? crc12(crc_q, cam_d_q) : crc_q;
      frame_crc_d = inc ? crc_q : frame_crc_q;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         crc_q       <= 16'hFFFF;
         frame_crc_q <= '0;
         crc_valid_q <= 1'b0;
      end else begin
         crc_q       <= crc_d;
         frame_crc_q <= frame_crc_d;
         crc_valid_q <= inc;
      end
   end

   assign frame_crc = frame_crc_q;
   assign crc_valid = crc_valid_q;
`endif
endmodule

// File: tb/tb_camera_stream_gen.sv
// tb_camera_stream_gen: directed vectors and frame-level sequences for camera_stream_gen
// with H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, FV_LEAD=3, FV_TRAIL=3, V_GAP=5.
module tb_camera_stream_gen;
   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic        enable = 1'b0, enable2 = 1'b0;
   logic [1:0]  pattern_sel = 2'd0, pattern2 = 2'd0;
   logic [15:0] frame_count, frame_count2;
   logic        busy, busy2;
   int          tests = 0, failed = 0;
   int          cyc = 0, last_rise = -1;

   camera_stream_gen_if cam();
   camera_stream_gen_if cam2();

`ifdef CAMGEN_FRAME_CRC_EN
   logic [15:0] frame_crc, frame_crc2;
   logic        crc_valid, crc_valid2;
`endif

   camera_stream_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .FV_LEAD(3), .FV_TRAIL(3), .V_GAP(5)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable), .pattern_sel(pattern_sel),
      .cam(cam), .frame_count(frame_count), .busy(busy)
`ifdef CAMGEN_FRAME_CRC_EN
      , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
   );

   camera_stream_gen #(.H_ACTIVE(16), .V_ACTIVE(4), .H_BLANK(2), .FV_LEAD(3), .FV_TRAIL(3), .V_GAP(5)) dut2 (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable2), .pattern_sel(pattern2),
      .cam(cam2), .frame_count(frame_count2), .busy(busy2)
`ifdef CAMGEN_FRAME_CRC_EN
      , .frame_crc(frame_crc2), .crc_valid(crc_valid2)
`endif
   );

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  pat;
      int          k;
      logic        fv, lv;
      logic [11:0] d;
      logic        bz;
   } vec_t;
   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] exp_pix(input logic [1:0] p, input int x, input int y, input logic [15:0] fc);
      logic [11:0] xv, yv;
      xv = 12'(x);
      yv = 12'(y);
      return p == 2'd0 ? xv : p == 2'd1 ? yv : p == 2'd2 ? {12{xv[3] ^ yv[3]}} : fc[11:0];
   endfunction

`ifdef CAMGEN_FRAME_CRC_EN
   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
         else r = r << 1;
      end
      return r;
   endfunction
`endif

   // Pulse enable for one sampled edge; returns at the k=0 sample point
   task automatic start(input logic [1:0] p);
      @(negedge clk_clk);
      enable = 1'b1;
      pattern_sel = p;
      @(negedge clk_clk);
      enable = 1'b0;
   endtask

   // Follow one whole frame on dut: geometry, pixels, count and (optionally) period
   task automatic watch_frame(input logic [1:0] pat, input logic [15:0] fc_in, input int chg,
                              input logic [1:0] new_pat, input bit drop, input bit per);
      int n, pulses, bad, x, y, t;
      logic prev_l;
      logic [15:0] fe;
`ifdef CAMGEN_FRAME_CRC_EN
      logic [15:0] bcrc;
      bcrc = 16'hFFFF;
`endif
      t = 0;
      while (!cam.cam_fval && t < 200) begin
         @(negedge clk_clk);
         t++;
      end
      if (!cam.cam_fval) begin
         chk("fval_rise_timeout", 32'(cam.cam_fval), 32'd1);
         return;
      end
      if (per) chk("frame_period", 32'(cyc - last_rise), 32'd49);
      last_rise = cyc;
      n = 0; pulses = 0; bad = 0; x = 0; y = 0; prev_l = 1'b0;
      while (cam.cam_fval && n < 1000) begin
         if (cam.cam_lval) begin
            if (!prev_l) pulses++;
            if (cam.cam_d !== exp_pix(pat, x, y, fc_in)) bad++;
`ifdef CAMGEN_FRAME_CRC_EN
            bcrc = crc_ref(bcrc, cam.cam_d);
`endif
            x++;
         end else begin
            if (prev_l) begin
               if (x != 8) bad++;
               y++;
               x = 0;
            end
            if (cam.cam_d !== 12'h000) bad++;
         end
`ifdef CAMGEN_FRAME_CRC_EN
         if (crc_valid) bad++;
`endif
         prev_l = cam.cam_lval;
         if (n == chg) pattern_sel = new_pat;
         if (drop && n == 15) enable = 1'b0;
         n++;
         @(negedge clk_clk);
      end
      fe = fc_in + 16'd1;
      chk("fval_length", 32'(n), 32'd44);
      chk("lval_pulses", 32'(pulses), 32'd4);
      chk("pixel_errors", 32'(bad), 32'd0);
      chk("frame_count_at_fval_fall", 32'(frame_count), 32'(fe));
`ifdef CAMGEN_FRAME_CRC_EN
      chk("frame_crc", 32'(frame_crc), 32'(bcrc));
      chk("crc_valid_pulse", 32'(crc_valid), 32'd1);
      @(negedge clk_clk);
      chk("crc_valid_single", 32'(crc_valid), 32'd0);
`endif
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while (busy && t < 100) begin
         @(negedge clk_clk);
         t++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   initial begin
      vt[0]  = '{2'd0, 0,  1'b0, 1'b0, 12'h000, 1'b0};
      vt[1]  = '{2'd0, 1,  1'b1, 1'b0, 12'h000, 1'b1};
      vt[2]  = '{2'd0, 3,  1'b1, 1'b0, 12'h000, 1'b1};
      vt[3]  = '{2'd0, 4,  1'b1, 1'b1, 12'h000, 1'b1};
      vt[4]  = '{2'd0, 8,  1'b1, 1'b1, 12'h004, 1'b1};
      vt[5]  = '{2'd0, 11, 1'b1, 1'b1, 12'h007, 1'b1};
      vt[6]  = '{2'd0, 12, 1'b1, 1'b0, 12'h000, 1'b1};
      vt[7]  = '{2'd0, 14, 1'b1, 1'b1, 12'h000, 1'b1};
      vt[8]  = '{2'd0, 41, 1'b1, 1'b1, 12'h007, 1'b1};
      vt[9]  = '{2'd0, 44, 1'b1, 1'b0, 12'h000, 1'b1};
      vt[10] = '{2'd0, 45, 1'b0, 1'b0, 12'h000, 1'b1};
      vt[11] = '{2'd0, 49, 1'b0, 1'b0, 12'h000, 1'b1};
      vt[12] = '{2'd0, 50, 1'b0, 1'b0, 12'h000, 1'b0};
      vt[13] = '{2'd1, 5,  1'b1, 1'b1, 12'h000, 1'b1};
      vt[14] = '{2'd1, 16, 1'b1, 1'b1, 12'h001, 1'b1};
      vt[15] = '{2'd1, 27, 1'b1, 1'b1, 12'h002, 1'b1};
      vt[16] = '{2'd1, 40, 1'b1, 1'b1, 12'h003, 1'b1};

      repeat (3) @(negedge clk_clk);
      chk("reset_fval", 32'(cam.cam_fval), 32'd0);
      chk("reset_lval", 32'(cam.cam_lval), 32'd0);
      chk("reset_d", 32'(cam.cam_d), 32'd0);
      chk("reset_frame_count", 32'(frame_count), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      chk("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 17; i++) begin
         start(vt[i].pat);
         repeat (vt[i].k) @(negedge clk_clk);
         chk($sformatf("vec%0d_k%0d", i, vt[i].k), {16'h0, cam.cam_fval, cam.cam_lval, cam.cam_d, busy},
             {16'h0, vt[i].fv, vt[i].lv, vt[i].d, vt[i].bz});
         repeat (60 - vt[i].k) @(negedge clk_clk);
      end
      chk("count_after_table", 32'(frame_count), 32'd17);

      start(2'd0);
      watch_frame(2'd0, 16'd17, -1, 2'd0, 1'b0, 1'b0);
      wait_idle("single_frame_idle");

      @(negedge clk_clk);
      enable2 = 1'b1;
      pattern2 = 2'd2;
      @(negedge clk_clk);
      enable2 = 1'b0;
      repeat (4) @(negedge clk_clk);
      for (int x = 0; x < 16; x++) begin
         chk($sformatf("checker_x%0d", x), {19'h0, cam2.cam_lval, cam2.cam_d}, {19'h0, 1'b1, (x >= 8) ? 12'hFFF : 12'h000});
         @(negedge clk_clk);
      end
      repeat (60) @(negedge clk_clk);

      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk_clk);
      release dut.frame_count_q;
      @(negedge clk_clk);
      chk("preset_ffff", 32'(frame_count), 32'hFFFF);
      start(2'd0);
      watch_frame(2'd0, 16'hFFFF, -1, 2'd0, 1'b0, 1'b0);
      chk("wrap_to_zero", 32'(frame_count), 32'd0);
      wait_idle("wrap_idle");

      start(2'd0);
      repeat (12) @(negedge clk_clk);
      chk("hblank_reached", {30'h0, cam.cam_fval, cam.cam_lval}, {30'h0, 1'b1, 1'b0});
      #2 reset_reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {13'h0, cam.cam_fval, cam.cam_lval, busy, cam.cam_d, frame_count[3:0]}, 32'd0);
      chk("async_reset_count", 32'(frame_count), 32'd0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      start(2'd0);
      watch_frame(2'd0, 16'd0, -1, 2'd0, 1'b0, 1'b0);
      wait_idle("post_reset_idle");

      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      enable = 1'b1;
      pattern_sel = 2'd3;
      watch_frame(2'd3, 16'd0, -1, 2'd0, 1'b0, 1'b0);
      watch_frame(2'd3, 16'd1, 10, 2'd0, 1'b0, 1'b1);
      watch_frame(2'd0, 16'd2, -1, 2'd0, 1'b1, 1'b1);
      wait_idle("enable_drop_idle");
      begin
         int hi;
         hi = 0;
         repeat (60) begin
            @(negedge clk_clk);
            if (cam.cam_fval || busy) hi++;
         end
         chk("stays_idle", 32'(hi), 32'd0);
      end
      chk("continuous_final_count", 32'(frame_count), 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
